// File: rtl/network_pkg.sv
// Shared network sizing constants and the output decoder state type.
// Imported by the output-layer spike decoder and its counters.
package network_pkg;

  localparam int OUTPUT_SIZE  = 4;
  localparam int SPIKE_WINDOW = 16;

  localparam int OUT_IDX_W   = $clog2(OUTPUT_SIZE);
  localparam int SPIKE_CNT_W = $clog2(SPIKE_WINDOW + 1);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    ARGMAX,
    DONE
  } decoder_state_t;

endpackage

// File: rtl/spike_counter.sv
// Per-neuron spike counter with synchronous clear and enable.
// Width is sized so a full window can never overflow it.
module spike_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/output_spike_decoder.sv
// Counts output-layer spikes over a window, then picks the winner
// with a one-index-per-cycle sequential argmax scan.
module output_spike_decoder
  import network_pkg::*;
#(
  parameter int NUM_OUT = OUTPUT_SIZE,
  parameter int WINDOW  = SPIKE_WINDOW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         tick,
  input  logic [NUM_OUT-1:0]           spike_in,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_OUT)-1:0]   class_idx,
  output logic [$clog2(WINDOW+1)-1:0]  max_count,
  output logic                         tie,
  output logic                         no_spike
);

  localparam int IW = $clog2(NUM_OUT);
  localparam int CW = $clog2(WINDOW + 1);

  decoder_state_t r_state;
  decoder_state_t w_next;

  logic [CW-1:0] r_tick_cnt;
  logic [IW-1:0] r_scan_idx;
  logic [IW-1:0] r_best_idx;
  logic [CW-1:0] r_best_cnt;
  logic          r_tie;

  logic [CW-1:0] w_cnt [NUM_OUT];
  logic [CW-1:0] w_sel;
  logic [IW-1:0] w_nbest_idx;
  logic [CW-1:0] w_nbest_cnt;
  logic          w_ntie;
  logic          w_clear;
  logic          w_count_en;
  logic          w_last_tick;
  logic          w_last_scan;

  assign w_clear     = (r_state == IDLE) && start;
  assign w_count_en  = (r_state == COUNT) && tick;
  assign w_last_tick = w_count_en && (r_tick_cnt == CW'(WINDOW - 1));
  assign w_last_scan = (r_state == ARGMAX) &&
                       (r_scan_idx == IW'(NUM_OUT - 1));

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_cnt
    spike_counter #(
      .W (CW)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_clear),
      .i_en    (w_count_en && spike_in[g]),
      .o_count (w_cnt[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != IDLE);
    done   = (r_state == DONE);
    unique case (r_state)
      IDLE:   if (start) w_next = COUNT;
      COUNT:  if (w_last_tick) w_next = ARGMAX;
      ARGMAX: if (w_last_scan) w_next = DONE;
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_tick_cnt <= '0;
    end else if (w_count_en) begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign w_sel = w_cnt[r_scan_idx];

  // Index 0 seeds the scan; later indices replace only on strictly greater
  always_comb begin
    w_nbest_idx = r_best_idx;
    w_nbest_cnt = r_best_cnt;
    w_ntie      = r_tie;
    if (r_scan_idx == '0) begin
      w_nbest_idx = '0;
      w_nbest_cnt = w_sel;
      w_ntie      = 1'b0;
    end else if (w_sel > r_best_cnt) begin
      w_nbest_idx = r_scan_idx;
      w_nbest_cnt = w_sel;
      w_ntie      = 1'b0;
    end else if (w_sel == r_best_cnt) begin
      w_ntie      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_idx <= '0;
      r_best_idx <= '0;
      r_best_cnt <= '0;
      r_tie      <= 1'b0;
      class_idx  <= '0;
      max_count  <= '0;
      tie        <= 1'b0;
      no_spike   <= 1'b0;
    end else if (r_state == COUNT) begin
      r_scan_idx <= '0;
    end else if (r_state == ARGMAX) begin
      r_scan_idx <= r_scan_idx + 1'b1;
      r_best_idx <= w_nbest_idx;
      r_best_cnt <= w_nbest_cnt;
      r_tie      <= w_ntie;
      if (w_last_scan) begin
        no_spike  <= (w_nbest_cnt == '0);
        class_idx <= (w_nbest_cnt == '0) ? '0 : w_nbest_idx;
        max_count <= w_nbest_cnt;
        tie       <= (w_nbest_cnt == '0) ? 1'b0 : w_ntie;
      end
    end
  end

endmodule

// File: tb/tb_output_spike_decoder.sv
// Directed and randomized windows for the output spike decoder,
// checked against a plain count-and-argmax reference model.
module tb_output_spike_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       tick;
  logic [3:0] spike_in;
  logic       busy;
  logic       done;
  logic [1:0] class_idx;
  logic [4:0] max_count;
  logic       tie;
  logic       no_spike;

  int checks = 0;
  int errors = 0;

  logic [3:0] pat [16];
  int prev_idx = 0;
  int prev_max = 0;
  int prev_tie = 0;
  int prev_ns  = 0;

  output_spike_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tick      (tick),
    .spike_in  (spike_in),
    .busy      (busy),
    .done      (done),
    .class_idx (class_idx),
    .max_count (max_count),
    .tie       (tie),
    .no_spike  (no_spike)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_idx"}, 32'(class_idx), 0);
    chk({tag, "_max"}, 32'(max_count), 0);
    chk({tag, "_tie"}, 32'(tie), 0);
    chk({tag, "_nospike"}, 32'(no_spike), 0);
  endtask

  task automatic run_window(input string tag, input int pre_gap,
                            input bit rand_gaps);
    int cnt [4];
    int exp_max, exp_idx, exp_tie, exp_ns, nmax, n;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int t = 0; t < 16; t++)
      for (int i = 0; i < 4; i++)
        if (pat[t][i]) cnt[i]++;
    exp_max = 0;
    for (int i = 0; i < 4; i++)
      if (cnt[i] > exp_max) exp_max = cnt[i];
    exp_idx = 0;
    for (int i = 3; i >= 0; i--)
      if (cnt[i] == exp_max) exp_idx = i;
    nmax = 0;
    for (int i = 0; i < 4; i++)
      if (cnt[i] == exp_max) nmax++;
    exp_ns  = (exp_max == 0) ? 1 : 0;
    exp_tie = (nmax > 1 && exp_max > 0) ? 1 : 0;
    if (exp_ns == 1) exp_idx = 0;

    start = 1'b1;
    step;
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 1);
    repeat (pre_gap) begin
      tick = 1'b0;
      spike_in = 4'hF;
      start = 1'($urandom_range(0, 1));
      step;
    end
    for (int t = 0; t < 16; t++) begin
      if (rand_gaps) begin
        repeat ($urandom_range(0, 2)) begin
          tick = 1'b0;
          spike_in = 4'($urandom);
          start = 1'($urandom_range(0, 1));
          step;
        end
      end
      tick = 1'b1;
      spike_in = pat[t];
      start = 1'($urandom_range(0, 1));
      step;
    end
    tick = 1'b0;
    spike_in = 4'($urandom);
    start = 1'b0;
    n = 1;
    chk({tag, "_hold_idx"}, 32'(class_idx), 32'(prev_idx));
    chk({tag, "_hold_max"}, 32'(max_count), 32'(prev_max));
    while (!done && n < 20) begin
      step;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 5);
    chk({tag, "_idx"}, 32'(class_idx), 32'(exp_idx));
    chk({tag, "_max"}, 32'(max_count), 32'(exp_max));
    chk({tag, "_tie"}, 32'(tie), 32'(exp_tie));
    chk({tag, "_nospike"}, 32'(no_spike), 32'(exp_ns));
    chk({tag, "_busy_done"}, 32'(busy), 1);
    start = 1'b1;
    step;
    start = 1'b0;
    chk({tag, "_start_at_done_ignored"}, 32'(busy), 0);
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_idx_held"}, 32'(class_idx), 32'(exp_idx));
    prev_idx = exp_idx;
    prev_max = exp_max;
    prev_tie = exp_tie;
    prev_ns  = exp_ns;
  endtask

  task automatic rand_pattern;
    int p [4];
    for (int i = 0; i < 4; i++) p[i] = $urandom_range(0, 100);
    for (int t = 0; t < 16; t++)
      for (int i = 0; i < 4; i++)
        pat[t][i] = ($urandom_range(0, 99) < p[i]);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    tick = 1'b0;
    spike_in = '0;
    repeat (3) step;
    chk_reset_outputs("reset");
    rst = 1'b0;

    for (int t = 0; t < 16; t++) pat[t] = 4'b0100;
    run_window("single", 0, 1'b0);

    for (int t = 0; t < 16; t++)
      pat[t] = (t < 8 ? 4'b1010 : 4'b0000) | (t < 3 ? 4'b0001 : 4'b0000);
    run_window("tie", 0, 1'b1);

    for (int t = 0; t < 16; t++)
      pat[t] = (t < 5 ? 4'b0011 : 4'b0000) | (t < 9 ? 4'b1000 : 4'b0000);
    run_window("tie_clear", 0, 1'b1);

    for (int t = 0; t < 16; t++) pat[t] = 4'b0000;
    run_window("silence", 0, 1'b1);

    for (int t = 0; t < 16; t++) pat[t] = 4'b0001;
    run_window("gating", 20, 1'b1);

    start = 1'b1;
    step;
    start = 1'b0;
    repeat (5) begin
      tick = 1'b1;
      spike_in = 4'hF;
      step;
    end
    tick = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk_reset_outputs("midreset");
    prev_idx = 0;
    prev_max = 0;
    prev_tie = 0;
    prev_ns  = 0;
    for (int t = 0; t < 16; t++) pat[t] = 4'b0010;
    run_window("after_reset", 0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      rand_pattern();
      run_window("random", 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
